mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage sitting directly downstream of the execute stage. It takes the execute result (`regcData`/`regcAddr`/`regcWr`) plus the instruction code each cycle. Load and store instructions go to a data memory over a request/acknowledge handshake, with a timeout and an alignment check. All other instructions pass straight through. Results are registered toward the register-file write port, and the block stalls the upstream pipeline while a memory access is outstanding.

## Interface
Parameters:
- `REG_LENGTH`, 32, data/address width.
- `REG_ADDR_LEN`, 5, register-number width.
- `OP_LENGTH`, 6, instruction-code width. `CMD_LW` and `CMD_SW` come from the shared command-code header.
- `MEM_TIMEOUT`, 16, maximum WAIT cycles without `memAck` before abort (≥2).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  OP_LENGTH  instruction code of the current execute result.
- `regcData_i`  in  REG_LENGTH  execute result; this is the effective address for LW/SW.
- `regcAddr_i`  in  REG_ADDR_LEN  destination register number.
- `regcWr_i`  in  1  destination write enable.
- `storeData_i`  in  REG_LENGTH  store data for SW.
- `valid_i`  in  1  execute result valid this cycle.
- `stall`  out  1  upstream must hold all inputs unchanged.
- `memReq`  out  1  memory request.
- `memWe`  out  1  1 = write (SW), 0 = read (LW).
- `memAddr`  out  REG_LENGTH  byte address.
- `memWdata`  out  REG_LENGTH  write data.
- `memAck`  in  1  memory completion, one-cycle pulse.
- `memRdata`  in  REG_LENGTH  read data, valid when `memAck`=1.
- `wbData`  out  REG_LENGTH  write-back data.
- `wbAddr`  out  REG_ADDR_LEN  write-back register number.
- `wbWr`  out  1  write-back enable, one-cycle pulse per retired instruction.
- `memErr`  out  1  one-cycle pulse on misaligned access or timeout.

## Operation
- There are two states, IDLE and WAIT. The state and all outputs except `stall` are registered.
- **IDLE, `valid_i`=0:** the next edge drives `wbWr`=0 and `memErr`=0. `wbData`/`wbAddr` hold.
- **IDLE, `valid_i`=1, non-memory op:** the next edge drives `wbData`=`regcData_i`, `wbAddr`=`regcAddr_i`, `wbWr`=`regcWr_i`. `stall`=0.
- **IDLE, `valid_i`=1, LW/SW with `regcData_i[1:0]`≠0 (misaligned):**
  - No request is issued and `stall`=0.
  - The next edge drives `memErr`=1 and `wbWr`=0.
- **IDLE, `valid_i`=1, LW/SW aligned:**
  - `stall`=1 combinationally.
  - The next edge enters WAIT and drives `memReq`=1, `memWe`=(op==`CMD_SW`), `memAddr`=`regcData_i`, `memWdata`=`storeData_i`.
  - The same edge latches `regcAddr_i` and `regcWr_i` internally and clears the timeout counter.
- **WAIT:**
  - `memReq`/`memWe`/`memAddr`/`memWdata` are held stable.
  - `stall`=~`memAck`.
  - The counter increments each cycle in which `memAck`=0.
- **WAIT, `memAck`=1 sampled:**
  - `memReq` drops to 0 and the state returns to IDLE.
  - For LW: `wbData`=`memRdata`, `wbAddr`=latched address, `wbWr`=latched `regcWr`.
  - For SW: `wbWr`=0.
- **WAIT, counter == `MEM_TIMEOUT`-1 and `memAck`=0:** abort. `memReq` drops to 0, `memErr`=1, `wbWr`=0, state returns to IDLE.
- **Simultaneous `memAck` and timeout:** `memAck` wins and the access completes normally.
- **`memAck` in IDLE:** ignored.
- **Inputs during WAIT:** ignored. Upstream is held by `stall`.
- **Reset:**
  - On `rst` rising, asynchronously: state IDLE, counter 0, and `memReq`, `memWe`, `memAddr`, `memWdata`, `wbData`, `wbAddr`, `wbWr`, `memErr` all 0.
  - `stall` evaluates to 0 while `rst`=1.
  - Reset during WAIT abandons the access with no write-back and no `memErr`.
  - A late `memAck` after reset is ignored.

## Timing
- Non-memory op: 1-cycle latency, `valid_i` at cycle n gives `wbWr` at n+1.
- LW/SW: `memReq` rises at n+1. If `memAck` is sampled at cycle n+k (k≥1), the write-back or completion shows at n+k+1, so the minimum latency is 2 cycles.
- `stall` is high from cycle n through the cycle before `memAck`. It is low in the `memAck` cycle, so upstream advances on the same edge, allowing back-to-back throughput.
- Timeout: with no ack, `memReq` is high for exactly `MEM_TIMEOUT` cycles, and `memErr` pulses in the following cycle.
- `wbWr` and `memErr` are never high for more than one consecutive cycle per instruction.

## Test plan
- Reset, then ADD result 0x0000_0007 → r3 with `regcWr_i`=1 → next cycle `wbData`=7, `wbAddr`=3, `wbWr`=1, `memReq` never asserts.
- LW addr 0x40 → r5, memory acks 3 cycles after `memReq` with 0xDEAD_BEEF → `stall` high for 3 cycles, `wbData`=0xDEAD_BEEF, `wbAddr`=5, `wbWr`=1 one cycle after ack.
- SW addr 0x44, data 0x1234_5678, ack in the first WAIT cycle → `memWe`=1, `memAddr`=0x44, `memWdata`=0x1234_5678, `wbWr` stays 0. A following ADD retires with no bubble.
- LW addr 0x41 → `memReq` stays 0, `stall` 0, `memErr`=1 for one cycle, `wbWr`=0.
- LW with no ack, `MEM_TIMEOUT`=16 → `memReq` high 16 cycles, then `memErr`=1 pulse, IDLE. `memAck` coinciding with the last cycle instead completes normally with no `memErr`.
- `rst` asserted mid-WAIT between edges → `memReq`=0 immediately. A later `memAck` produces no `wbWr`, and a new LW after reset completes correctly.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; routes LW/SW to data memory over req/ack, passes other ops straight to write-back
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   op, regcData_i, regcAddr_i,      execute result; regcData_i is the effective address for LW/SW
//   regcWr_i, storeData_i, valid_i
//   stall                            combinational hold request to upstream
//   memReq, memWe, memAddr,          registered memory request side
//   memWdata
//   memAck, memRdata                 memory completion pulse and read data
//   wbData, wbAddr, wbWr             registered register-file write port
//   memErr                           one-cycle pulse on misaligned access or timeout
module mem_stage #(
    parameter int              REG_LENGTH   = 32,
    parameter int              REG_ADDR_LEN = 5,
    parameter int              OP_LENGTH    = 6,
    parameter int              MEM_TIMEOUT  = 16,
    parameter logic [OP_LENGTH-1:0] CMD_LW  = 6'h23,
    parameter logic [OP_LENGTH-1:0] CMD_SW  = 6'h2B
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_LENGTH-1:0]    op,
    input  logic [REG_LENGTH-1:0]   regcData_i,
    input  logic [REG_ADDR_LEN-1:0] regcAddr_i,
    input  logic                    regcWr_i,
    input  logic [REG_LENGTH-1:0]   storeData_i,
    input  logic                    valid_i,
    output logic                    stall,
    output logic                    memReq,
    output logic                    memWe,
    output logic [REG_LENGTH-1:0]   memAddr,
    output logic [REG_LENGTH-1:0]   memWdata,
    input  logic                    memAck,
    input  logic [REG_LENGTH-1:0]   memRdata,
    output logic [REG_LENGTH-1:0]   wbData,
    output logic [REG_ADDR_LEN-1:0] wbAddr,
    output logic                    wbWr,
    output logic                    memErr
);
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [REG_ADDR_LEN-1:0] lat_addr;
    logic                    lat_wr;
    logic                    is_mem;
    logic                    misaligned;

    assign is_mem     = (op == CMD_LW) || (op == CMD_SW);
    assign misaligned = |regcData_i[1:0];

    // Low in the ack cycle so upstream advances on the completing edge.
    assign stall = !rst && (state == WAIT ? !memAck : valid_i && is_mem && !misaligned);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            wbData   <= '0;
            wbAddr   <= '0;
            wbWr     <= 1'b0;
            memErr   <= 1'b0;
        end else begin
            wbWr   <= 1'b0;
            memErr <= 1'b0;
            if (state == IDLE) begin
                if (valid_i) begin
                    if (!is_mem) begin
                        wbData <= regcData_i;
                        wbAddr <= regcAddr_i;
                        wbWr   <= regcWr_i;
                    end else if (misaligned) begin
                        memErr <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        cnt      <= '0;
                        memReq   <= 1'b1;
                        memWe    <= (op == CMD_SW);
                        memAddr  <= regcData_i;
                        memWdata <= storeData_i;
                        lat_addr <= regcAddr_i;
                        lat_wr   <= regcWr_i;
                    end
                end
            end else if (memAck) begin
                // Ack takes priority over a coinciding timeout.
                state  <= IDLE;
                memReq <= 1'b0;
                if (!memWe) begin
                    wbData <= memRdata;
                    wbAddr <= lat_addr;
                    wbWr   <= lat_wr;
                end
            end else if (cnt == CNT_LAST) begin
                state  <= IDLE;
                memReq <= 1'b0;
                memErr <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage
module tb_mem_stage;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] ADD = 6'h20;

    logic        clk = 0;
    logic        rst = 1;
    logic [5:0]  op = '0;
    logic [31:0] regcData_i = '0;
    logic [4:0]  regcAddr_i = '0;
    logic        regcWr_i = 0;
    logic [31:0] storeData_i = '0;
    logic        valid_i = 0;
    logic        stall, memReq, memWe, memAck = 0;
    logic [31:0] memAddr, memWdata, memRdata = '0, wbData;
    logic [4:0]  wbAddr;
    logic        wbWr, memErr;

    typedef struct {logic err; logic [31:0] data; logic [4:0] addr;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    mem_stage #(.REG_LENGTH(32), .REG_ADDR_LEN(5), .OP_LENGTH(6), .MEM_TIMEOUT(16),
                .CMD_LW(LW), .CMD_SW(SW)) dut (
        .clk(clk), .rst(rst), .op(op), .regcData_i(regcData_i), .regcAddr_i(regcAddr_i),
        .regcWr_i(regcWr_i), .storeData_i(storeData_i), .valid_i(valid_i), .stall(stall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memAck(memAck), .memRdata(memRdata), .wbData(wbData), .wbAddr(wbAddr),
        .wbWr(wbWr), .memErr(memErr));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && (wbWr || memErr)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire wbWr=%b memErr=%b wbData=%h required no event", wbWr, memErr, wbData);
            end else begin
                e = q.pop_front();
                if (e.err ? (memErr !== 1'b1 || wbWr !== 1'b0)
                          : (wbWr !== 1'b1 || memErr !== 1'b0 || wbData !== e.data || wbAddr !== e.addr)) begin
                    errors++;
                    $display("FAIL retire got wbWr=%b memErr=%b data=%h addr=%0d required err=%b data=%h addr=%0d",
                             wbWr, memErr, wbData, wbAddr, e.err, e.data, e.addr);
                end
            end
        end
    end

    task automatic drive(input logic [5:0] o, input logic [31:0] d, input logic [4:0] a,
                         input logic w, input logic [31:0] sd);
        op = o; regcData_i = d; regcAddr_i = a; regcWr_i = w; storeData_i = sd; valid_i = 1;
    endtask

    task automatic test_reset;
        drive(LW, 32'h40, 5'd1, 1, 0);
        @(negedge clk);
        checks++;
        if (memReq !== 0 || wbWr !== 0 || memErr !== 0 || stall !== 0 || wbData !== 0) begin
            errors++;
            $display("FAIL reset_state memReq=%b wbWr=%b memErr=%b stall=%b wbData=%h required all 0",
                     memReq, wbWr, memErr, stall, wbData);
        end
        valid_i = 0;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_alu;
        drive(ADD, 32'h7, 5'd3, 1, 0);
        q.push_back('{0, 32'h7, 5'd3});
        #1;
        checks++;
        if (stall !== 0) begin errors++; $display("FAIL alu_stall got %b required 0", stall); end
        @(negedge clk);
        valid_i = 0;
        checks++;
        if (memReq !== 0) begin errors++; $display("FAIL alu_memreq got %b required 0", memReq); end
        @(negedge clk);
    endtask

    task automatic test_lw_ack;
        int sc = 0;
        drive(LW, 32'h40, 5'd5, 1, 0);
        q.push_back('{0, 32'hDEADBEEF, 5'd5});
        #1 if (stall) sc++;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (memReq !== 1 || memWe !== 0 || memAddr !== 32'h40) begin
                errors++;
                $display("FAIL lw_req cyc%0d memReq=%b memWe=%b memAddr=%h required 1 0 00000040", i, memReq, memWe, memAddr);
            end
            if (i == 3) begin memAck = 1; memRdata = 32'hDEADBEEF; end
            #1 if (stall) sc++;
        end
        @(negedge clk);
        memAck = 0; valid_i = 0;
        checks++;
        if (memReq !== 0 || sc != 3) begin
            errors++;
            $display("FAIL lw_done memReq=%b stall_cycles=%0d required 0 and 3", memReq, sc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        drive(SW, 32'h44, 5'd2, 0, 32'h12345678);
        @(negedge clk);
        checks++;
        if (memReq !== 1 || memWe !== 1 || memAddr !== 32'h44 || memWdata !== 32'h12345678) begin
            errors++;
            $display("FAIL sw_req memReq=%b memWe=%b memAddr=%h memWdata=%h required 1 1 00000044 12345678",
                     memReq, memWe, memAddr, memWdata);
        end
        memAck = 1;
        #1;
        checks++;
        if (stall !== 0) begin errors++; $display("FAIL sw_ack_stall got %b required 0", stall); end
        @(negedge clk);
        memAck = 0;
        drive(ADD, 32'h99, 5'd7, 1, 0);
        q.push_back('{0, 32'h99, 5'd7});
        checks++;
        if (wbWr !== 0 || memReq !== 0) begin
            errors++;
            $display("FAIL sw_done wbWr=%b memReq=%b required 0 0", wbWr, memReq);
        end
        @(negedge clk);
        valid_i = 0;
        checks++;
        if (wbWr !== 1) begin errors++; $display("FAIL add_no_bubble wbWr=%b required 1", wbWr); end
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        drive(LW, 32'h41, 5'd6, 1, 0);
        q.push_back('{1, 32'h0, 5'd0});
        #1;
        checks++;
        if (stall !== 0) begin errors++; $display("FAIL mis_stall got %b required 0", stall); end
        @(negedge clk);
        valid_i = 0;
        checks++;
        if (memReq !== 0) begin errors++; $display("FAIL mis_memreq got %b required 0", memReq); end
        @(negedge clk);
        checks++;
        if (memErr !== 0) begin errors++; $display("FAIL mis_pulse memErr=%b required 0", memErr); end
    endtask

    task automatic test_timeout;
        int rc = 0;
        drive(LW, 32'h80, 5'd8, 1, 0);
        q.push_back('{1, 32'h0, 5'd0});
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (memReq) rc++;
            else break;
        end
        valid_i = 0;
        checks++;
        if (rc != 16) begin errors++; $display("FAIL timeout_len memReq_cycles=%0d required 16", rc); end
        @(negedge clk);
        drive(LW, 32'h84, 5'd9, 1, 0);
        q.push_back('{0, 32'hCAFEF00D, 5'd9});
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (memReq !== 1) begin errors++; $display("FAIL late_ack_req cyc%0d memReq=%b required 1", i, memReq); end
            if (i == 16) begin memAck = 1; memRdata = 32'hCAFEF00D; end
        end
        @(negedge clk);
        memAck = 0; valid_i = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_midwait;
        drive(LW, 32'h90, 5'd10, 1, 0);
        @(negedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if (memReq !== 0 || stall !== 0) begin
            errors++;
            $display("FAIL rst_midwait memReq=%b stall=%b required 0 0", memReq, stall);
        end
        @(negedge clk);
        valid_i = 0; rst = 0;
        @(negedge clk);
        memAck = 1; memRdata = 32'h11111111;
        @(negedge clk);
        memAck = 0;
        @(negedge clk);
        checks++;
        if (wbWr !== 0 || memReq !== 0) begin
            errors++;
            $display("FAIL stale_ack wbWr=%b memReq=%b required 0 0", wbWr, memReq);
        end
        drive(LW, 32'hA0, 5'd11, 1, 0);
        q.push_back('{0, 32'h55AA55AA, 5'd11});
        @(negedge clk);
        memAck = 1; memRdata = 32'h55AA55AA;
        @(negedge clk);
        memAck = 0; valid_i = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_alu;
        test_lw_ack;
        test_back_to_back;
        test_misaligned;
        test_timeout;
        test_reset_midwait;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t required completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
